uart_rx_ctrl: RTL and testbench

Receive-side controller of the UART RX path. Oversamples the raw serial line, majority-votes each bit, and sequences start/data/parity/stop. Deserializes the data byte and flags stop errors. Directly drives the downstream parity checker (`P_DATA`, `sampled_bit`, `par_chk_en`, `done_chk`) and consumes its `par_err` result before declaring a frame valid.

---
 rtl/uart_rx_ctrl.sv | 144 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled 2-of-3 bit voting, start/data/parity/stop sequencing.
// Define UART_RX_ERR_CNT_EN to add the saturating err_cnt frame-error counter output.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
  input  logic                  PAR_EN,
  input  logic                  par_err,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  sampled_bit,
  output logic                  par_chk_en,
  output logic                  done_chk,
  output logic                  data_valid,
  output logic                  stp_err
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [5:0]            r_ps_q;
  logic                  r_par_en_q;
  logic [5:0]            r_edge_cnt;
  logic [BCW-1:0]        r_bit_cnt;
  logic [2:0]            r_samp;
  logic                  r_sampled_bit;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_stp_err;

  logic [5:0] w_mid;
  logic       w_last;
  logic       w_vote;
  logic       w_stop_last;
  logic       w_frame_err;

  // Wrapping 6-bit compare keeps illegal Prescale values from stalling the counter.
  assign w_mid       = r_ps_q >> 1;
  assign w_last      = (r_edge_cnt == (r_ps_q - 6'd1));
  assign w_vote      = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_samp[2]) | (r_samp[1] & r_samp[2]);
  assign w_stop_last = (r_state == S_STOP) && w_last;
  assign w_frame_err = ~r_sampled_bit | (r_par_en_q & par_err);

  assign P_DATA      = r_p_data;
  assign sampled_bit = r_sampled_bit;
  assign stp_err     = r_stp_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first; a missed branch would otherwise infer a latch.
  always_comb begin
    w_next     = r_state;
    par_chk_en = 1'b0;
    done_chk   = 1'b0;
    data_valid = 1'b0;
    case (r_state)
      S_IDLE:   if (!RX_IN) w_next = S_START;
      S_START:  if (w_last) w_next = r_sampled_bit ? S_IDLE : S_DATA;
      S_DATA:   if (w_last && (r_bit_cnt == LAST_BIT)) w_next = r_par_en_q ? S_PARITY : S_STOP;
      S_PARITY: begin
        if (w_last) begin
          par_chk_en = 1'b1;
          w_next     = S_STOP;
        end
      end
      S_STOP: begin
        if (w_last) begin
          done_chk   = 1'b1;
          data_valid = ~w_frame_err;
          w_next     = S_IDLE;
        end
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ps_q        <= '0;
      r_par_en_q    <= 1'b0;
      r_edge_cnt    <= '0;
      r_bit_cnt     <= '0;
      r_samp        <= '0;
      r_sampled_bit <= 1'b0;
      r_p_data      <= '0;
      r_stp_err     <= 1'b0;
    end else begin
      if (r_state == S_IDLE) begin
        // The start-detect cycle is edge 0 of the start bit.
        r_edge_cnt <= RX_IN ? 6'd0 : 6'd1;
        if (!RX_IN) begin
          r_ps_q     <= Prescale;
          r_par_en_q <= PAR_EN;
        end
      end else begin
        r_edge_cnt <= w_last ? 6'd0 : r_edge_cnt + 6'd1;
        if (r_edge_cnt == w_mid - 6'd1) r_samp[0] <= RX_IN;
        if (r_edge_cnt == w_mid)        r_samp[1] <= RX_IN;
        if (r_edge_cnt == w_mid + 6'd1) r_samp[2] <= RX_IN;
        if (r_edge_cnt == w_mid + 6'd2) r_sampled_bit <= w_vote;
      end

      if ((r_state == S_DATA) && w_last) begin
        r_p_data[r_bit_cnt] <= r_sampled_bit;
        r_bit_cnt           <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
      end

      // A stop error persists until a genuine start bit is accepted, not just a glitch.
      if ((r_state == S_START) && w_last && !r_sampled_bit) r_stp_err <= 1'b0;
      if (w_stop_last) r_stp_err <= ~r_sampled_bit;
    end
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                               r_err_cnt <= '0;
    else if (w_stop_last && w_frame_err && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
  end

  assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table of frames driven serially, scoreboard of expected frame results,
// plus hand sequences for start glitch and mid-frame reset. Includes a registered even-parity checker model.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       par_err;
  logic [7:0] P_DATA;
  logic       sampled_bit;
  logic       par_chk_en;
  logic       done_chk;
  logic       data_valid;
  logic       stp_err;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .par_err    (par_err),
    .P_DATA     (P_DATA),
    .sampled_bit(sampled_bit),
    .par_chk_en (par_chk_en),
    .done_chk   (done_chk),
    .data_valid (data_valid),
    .stp_err    (stp_err)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ps;
    logic       par_en;
    logic [7:0] data;
    logic       par_flip;
    logic       stop_bad;
    logic       flip_mid;
    int         gap;
    logic       exp_valid;
    logic       exp_stp;
  } vec_t;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        stp;
    int          par_n;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int          par_n = 0;
  int          dv_total = 0;
  int          done_total = 0;
  logic        pend = 1'b0;
  logic        pend_stp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered even-parity checker: flags on the parity strobe, clears after frame end.
  always @(posedge clk or negedge rst) begin
    if (!rst)            par_err <= 1'b0;
    else if (par_chk_en) par_err <= ^{P_DATA, sampled_bit};
    else if (done_chk)   par_err <= 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      par_n = 0;
      pend  = 1'b0;
    end else begin
      if (pend) begin
        check("stp_err_after_stop", {31'd0, stp_err}, {31'd0, pend_stp});
        check("data_valid_width", {31'd0, data_valid}, 32'd0);
        check("done_chk_width", {31'd0, done_chk}, 32'd0);
        pend = 1'b0;
      end
      if (par_chk_en) par_n++;
      if (data_valid) dv_total++;
      if (done_chk) begin
        done_total++;
        if (sb_q.size() == 0) begin
          check("unexpected_done", {31'd0, done_chk}, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("frame_latency", cyc, mon_e.due);
          check("data_valid", {31'd0, data_valid}, {31'd0, mon_e.valid});
          check("P_DATA", {24'd0, P_DATA}, {24'd0, mon_e.data});
          check("par_chk_en_count", par_n, mon_e.par_n);
          pend     = 1'b1;
          pend_stp = mon_e.stp;
        end
        par_n = 0;
      end
    end
  end

  function automatic vec_t mk(input logic [5:0] ps, input logic par_en, input logic [7:0] data,
                              input logic par_flip, input logic stop_bad, input logic flip_mid,
                              input int gap, input logic exp_valid, input logic exp_stp);
    vec_t v;
    v.ps = ps; v.par_en = par_en; v.data = data; v.par_flip = par_flip; v.stop_bad = stop_bad;
    v.flip_mid = flip_mid; v.gap = gap; v.exp_valid = exp_valid; v.exp_stp = exp_stp;
    return v;
  endfunction

  task automatic send_frame(input vec_t v);
    logic [11:0] bits;
    int          nb;
    exp_t        e;
    logic        flip;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = v.data[i];
    nb = 9;
    if (v.par_en) begin
      bits[nb] = (^v.data) ^ v.par_flip;
      nb = nb + 1;
    end
    bits[nb] = ~v.stop_bad;
    nb = nb + 1;
    for (int i = 0; i < nb; i++) begin
      for (int k = 0; k < int'(v.ps); k++) begin
        @(negedge clk);
        if (i == 0 && k == 0) begin
          Prescale = v.ps;
          PAR_EN   = v.par_en;
          e.data   = v.data;
          e.valid  = v.exp_valid;
          e.stp    = v.exp_stp;
          e.par_n  = v.par_en ? 1 : 0;
          e.due    = cyc + (2 + 8 + (v.par_en ? 1 : 0)) * int'(v.ps) - 1;
          sb_q.push_back(e);
        end
        // Scrambled mid-frame so the latched copies are what count.
        if (i == 0 && k == 1) begin
          Prescale = 6'd13;
          PAR_EN   = ~v.par_en;
        end
        flip  = v.flip_mid && (i >= 1) && (i <= 8) && (k == int'(v.ps) / 2 - 1);
        RX_IN = bits[i] ^ flip;
      end
    end
    repeat (v.gap) begin
      @(negedge clk);
      RX_IN = 1'b1;
    end
  endtask

  task automatic drain(input string name);
    for (int t = 0; t < 4000 && sb_q.size() != 0; t++) @(negedge clk);
    check(name, sb_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_P_DATA"}, {24'd0, P_DATA}, 32'd0);
    check({tag, "_sampled_bit"}, {31'd0, sampled_bit}, 32'd0);
    check({tag, "_par_chk_en"}, {31'd0, par_chk_en}, 32'd0);
    check({tag, "_done_chk"}, {31'd0, done_chk}, 32'd0);
    check({tag, "_data_valid"}, {31'd0, data_valid}, 32'd0);
    check({tag, "_stp_err"}, {31'd0, stp_err}, 32'd0);
  endtask

  task automatic glitch_seq();
    int dv0;
    int d0;
    dv0 = dv_total;
    d0  = done_total;
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    @(negedge clk); RX_IN = 1'b0;
    @(negedge clk); RX_IN = 1'b0;
    @(negedge clk); RX_IN = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_no_data_valid", dv_total, dv0);
    check("glitch_no_done_chk", done_total, d0);
    check("glitch_stp_err_held", {31'd0, stp_err}, 32'd1);
  endtask

  task automatic reset_mid_data();
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      RX_IN = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      RX_IN = 1'b1;
    end
    check("pre_reset_sampled_bit", {31'd0, sampled_bit}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  vec_t tbl[8];
  int   exp_dv;

  initial begin
    tbl[0] = mk(6'd8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 8,  1'b1, 1'b0);
    tbl[1] = mk(6'd16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8,  1'b1, 1'b0);
    tbl[2] = mk(6'd16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8,  1'b0, 1'b0);
    tbl[3] = mk(6'd8,  1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 10, 1'b0, 1'b1);
    tbl[4] = mk(6'd8,  1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 6,  1'b1, 1'b0);
    tbl[5] = mk(6'd32, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 4,  1'b1, 1'b0);
    tbl[6] = mk(6'd8,  1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 0,  1'b1, 1'b0);
    tbl[7] = mk(6'd8,  1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 8,  1'b1, 1'b0);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    check_all_zero("after_reset");

    exp_dv = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        drain("drain_before_glitch");
        glitch_seq();
      end
      send_frame(tbl[i]);
      if (tbl[i].exp_valid) exp_dv++;
    end
    drain("drain_table");
    check("data_valid_total", dv_total, exp_dv);

    reset_mid_data();
    check("queue_empty_after_reset", sb_q.size(), 0);
    send_frame(mk(6'd8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b0));
    exp_dv++;
    drain("drain_after_reset");
    check("data_valid_total_final", dv_total, exp_dv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
